imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_byte_asm.sv | 53 +++++
 rtl/imem_loader.sv | 112 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction memory loader.
//   ld_state_t : loader FSM state encoding (IDLE / LOAD / DONE)
//   NOP        : instruction word driven on inst while the loader owns memory
//   bc_width() : width of a byte counter for a given bytes-per-word count
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // A one-byte word still needs a 1-bit counter so the port/reg is legal.
  function automatic int bc_width(input int bytes_per_word);
    return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
  endfunction

endpackage

// File: rtl/imem_byte_asm.sv
// imem_byte_asm: big-endian byte-to-word assembler for the program loader.
// The first accepted byte of a word lands in the most significant byte.
// Ports:
//   clk        : clock, state updates on the falling edge
//   rst        : synchronous active-high reset (clears counter and shift reg)
//   clr        : synchronous clear at the start of a new load
//   byte_en    : a byte is accepted on this edge
//   byte_in    : accepted byte
//   word       : completed word (valid together with word_valid)
//   word_valid : the byte accepted on this edge completes a word
module imem_byte_asm
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  localparam int BPW  = DATA_W / 8;
  localparam int BC_W = bc_width(BPW);

  logic [DATA_W-1:0] sr;
  logic [BC_W-1:0]   bc;
  logic              last_byte;

  assign last_byte  = (bc == BC_W'(BPW - 1));
  // Shifting left and or-ing the new byte in keeps the first byte on top.
  assign word       = (sr << 8) | DATA_W'(byte_in);
  assign word_valid = byte_en && last_byte;

  // With byte_en low nothing moves, so stalls of any length are harmless.
  always_ff @(negedge clk) begin
    if (rst || clr) begin
      sr <= '0;
      bc <= '0;
    end else if (byte_en) begin
      if (last_byte) begin
        sr <= '0;
        bc <= '0;
      end else begin
        sr <= word;
        bc <= bc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: instruction memory with a byte-serial program loader.
// All state updates on the falling edge of clk.
// Handshake: a loader byte is transferred on a falling edge where
// ld_valid && ld_ready; ld_ready is high only in LOAD, and ld_valid may drop
// for any number of cycles without losing assembled bytes.
// Ports:
//   clk, resetpc       : clock and synchronous active-high reset
//   addr / inst        : fetch index and registered instruction (NOP while loading)
//   ld_start, ld_len   : load request and word count (1..2**ADDR_W)
//   ld_valid, ld_byte  : loader byte stream
//   ld_ready           : loader may transfer a byte
//   busy               : FSM not in IDLE
//   ld_done            : one-cycle pulse after the final word is written
//   ld_err             : one-cycle pulse for a rejected ld_start
//   dbg_state          : current FSM state
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetpc,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] inst,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              busy,
  output logic              ld_done,
  output logic              ld_err,
  output ld_state_t         dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  ld_state_t         state;
  ld_state_t         state_next;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] last_idx;
  logic              len_ok;
  logic              start_ok;
  logic              accept;
  logic [DATA_W-1:0] word;
  logic              word_valid;
  logic              last_word;

  assign len_ok   = (ld_len != '0) && (ld_len <= (ADDR_W + 1)'(DEPTH));
  assign start_ok = (state == ST_IDLE) && ld_start && len_ok;
  // Reset wins over a byte on the same edge.
  assign accept    = ld_valid && ld_ready && !resetpc;
  assign last_word = word_valid && (wp == last_idx);

  assign ld_ready  = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);
  assign ld_done   = (state == ST_DONE);
  assign dbg_state = state;

  imem_byte_asm #(
    .DATA_W(DATA_W)
  ) u_asm (
    .clk       (clk),
    .rst       (resetpc),
    .clr       (start_ok),
    .byte_en   (accept),
    .byte_in   (ld_byte),
    .word      (word),
    .word_valid(word_valid)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_ok)  state_next = ST_LOAD;
      ST_LOAD: if (last_word) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // last_idx = ld_len-1 always fits ADDR_W bits, so the final write lands at
  // most at DEPTH-1; wp may wrap afterwards but nothing is written then.
  always_ff @(negedge clk) begin
    if (resetpc) begin
      state    <= ST_IDLE;
      wp       <= '0;
      last_idx <= '0;
      ld_err   <= 1'b0;
      inst     <= DATA_W'(NOP);
    end else begin
      state  <= state_next;
      ld_err <= (state == ST_IDLE) && ld_start && !len_ok;
      if (start_ok) begin
        wp       <= '0;
        last_idx <= ADDR_W'(ld_len - 1'b1);
      end else if (word_valid) begin
        wp <= wp + 1'b1;
      end
      inst <= (state == ST_IDLE) ? mem[addr] : DATA_W'(NOP);
    end
  end

  // Memory has no reset: contents survive resetpc.
  always_ff @(negedge clk) begin
    if (word_valid) mem[wp] <= word;
  end

endmodule
